// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared mode constants and width helper for priority encoders/arbiters
package prio_pkg;

  localparam int FIXED_PRIO  = 0;
  localparam int ROUND_ROBIN = 1;

  // Index width that never collapses to zero for the smallest legal N.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_hs_if.sv
// rtl/prio_encoder_hs_if.sv - valid/ready index handshake between encoder and its consumer
interface prio_encoder_hs_if
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = clog2_safe(N)
);

  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);

endinterface

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational fixed-priority / round-robin single-bit picker
module prio_pick
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = clog2_safe(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start_ptr,
  input  logic             mode,      // 1 = round-robin, 0 = highest index wins
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan order is arranged so the last hit written is the winner; IDX_W-bit adds wrap modulo N.
  always_comb begin
    sel  = '0;
    cand = '0;
    any  = |vec;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = start_ptr + IDX_W'(1) + IDX_W'(k);
        if (vec[cand]) sel = cand;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) sel = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_hs.sv
// rtl/prio_encoder_hs.sv - sticky request capture, priority encode and valid/ready index delivery
module prio_encoder_hs
  import prio_pkg::*;
#(
  parameter int N       = 8,
  parameter int IDX_W   = clog2_safe(N),
  parameter int RR_MODE = FIXED_PRIO
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  prio_encoder_hs_if.master    out_if,
  output logic [N-1:0]         pending,
  output logic                 busy,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam logic MODE = (RR_MODE == ROUND_ROBIN);

  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W-1:0] sel;
  logic             any;
  logic             slot_free;
  logic             grant;
  logic [N-1:0]     clr_mask;

  // Selection looks only at registered pending, never at this cycle's req.
  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec       (pending_q),
    .start_ptr (ptr_q),
    .mode      (MODE),
    .sel       (sel),
    .any       (any)
  );

  // Next-state: grant into a free slot, set-wins pending capture, sticky overflow.
  always_comb begin
    slot_free = !valid_q || out_if.out_ready;
    grant     = slot_free && any;
    clr_mask  = '0;
    if (grant) clr_mask[sel] = 1'b1;

    pending_d = (pending_q & ~clr_mask) | req;

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (|(req & pending_q & ~clr_mask)) ovf_d = 1'b1;

    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (slot_free) begin
      valid_d = any;
      if (any) begin
        idx_d = sel;
        if (MODE) ptr_d = sel;
      end
    end
  end

  // State registers; pointer resets to N-1 so the first round-robin scan starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      ptr_q     <= IDX_W'(N - 1);
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_if.out_idx   = idx_q;
  assign out_if.out_valid = valid_q;
  assign pending          = pending_q;
  assign busy             = (|pending_q) || valid_q;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// tb/tb_prio_encoder_hs.sv - scoreboard bench for fixed and round-robin encoder instances
module tb_prio_encoder_hs;
  import prio_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic       ovf_clr;
  logic [7:0] pend_f, pend_r;
  logic       busy_f, busy_r, ovf_f, ovf_r;

  int n_checks = 0;
  int n_fail   = 0;

  prio_encoder_hs_if #(.N(N), .IDX_W(3)) if_fix ();
  prio_encoder_hs_if #(.N(N), .IDX_W(3)) if_rr ();
  assign if_fix.out_ready = out_ready;
  assign if_rr.out_ready  = out_ready;

  prio_encoder_hs #(.N(N), .IDX_W(3), .RR_MODE(FIXED_PRIO)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .out_if(if_fix.master),
    .pending(pend_f), .busy(busy_f), .ovf(ovf_f), .ovf_clr(ovf_clr)
  );

  prio_encoder_hs #(.N(N), .IDX_W(3), .RR_MODE(ROUND_ROBIN)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_if(if_rr.master),
    .pending(pend_r), .busy(busy_r), .ovf(ovf_r), .ovf_clr(ovf_clr)
  );

  initial forever #5 clk = ~clk;

  // Reference state: index 0 = fixed-priority instance, 1 = round-robin instance.
  int m_pend[2];
  int m_idx[2];
  int m_ptr[2];
  bit m_valid[2];
  bit m_ovf[2];
  int exp_fix[$];
  int exp_rr[$];
  int log_fix[$];
  int log_rr[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string log_str(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) begin
      if (i == 0) s = $sformatf("%0d", q[i]);
      else        s = $sformatf("%s %0d", s, q[i]);
    end
    return s;
  endfunction

  function automatic int ref_pick(input int inst, input int vec);
    int j;
    if (inst == 0) begin
      for (int i = N - 1; i >= 0; i--) if (((vec >> i) & 1) != 0) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr[inst] + k) % N;
        if (((vec >> j) & 1) != 0) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input int inst, input int r, input bit rdy, input bit clr);
    int g;
    bit hit;
    g   = -1;
    hit = 1'b0;
    if (!m_valid[inst] || rdy) begin
      if (m_pend[inst] != 0) begin
        g = ref_pick(inst, m_pend[inst]);
        m_valid[inst] = 1'b1;
        m_idx[inst]   = g;
        if (inst == 0) exp_fix.push_back(g);
        else begin
          exp_rr.push_back(g);
          m_ptr[inst] = g;
        end
      end else begin
        m_valid[inst] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++)
      if (((r >> i) & 1) != 0 && ((m_pend[inst] >> i) & 1) != 0 && i != g) hit = 1'b1;
    if (hit) m_ovf[inst] = 1'b1;
    else if (clr) m_ovf[inst] = 1'b0;
    if (g >= 0) m_pend[inst] = m_pend[inst] & ~(1 << g);
    m_pend[inst] = m_pend[inst] | r;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_idx[k] = 0; m_ptr[k] = N - 1; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
      end
      exp_fix.delete();
      exp_rr.delete();
    end else begin
      model_step(0, int'(req), out_ready, ovf_clr);
      model_step(1, int'(req), out_ready, ovf_clr);
    end
  end

  task automatic mon(input int inst, input int pend, input bit valid, input int idx,
                     input bit bsy, input bit ov);
    string nm;
    int e;
    bit have;
    e = 0;
    have = 1'b0;
    if (inst == 0) nm = "fix";
    else           nm = "rr";
    check({nm, " pending"}, pend, m_pend[inst]);
    check({nm, " out_valid"}, int'(valid), int'(m_valid[inst]));
    check({nm, " busy"}, int'(bsy), int'((m_pend[inst] != 0) || m_valid[inst]));
    check({nm, " ovf"}, int'(ov), int'(m_ovf[inst]));
    if (valid && out_ready) begin
      if (inst == 0) begin
        have = (exp_fix.size() > 0);
        if (have) e = exp_fix.pop_front();
        log_fix.push_back(idx);
      end else begin
        have = (exp_rr.size() > 0);
        if (have) e = exp_rr.pop_front();
        log_rr.push_back(idx);
      end
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s grant: got idx %0d expected no grant", nm, idx);
      end else begin
        check({nm, " grant idx"}, idx, e);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      mon(0, int'(pend_f), if_fix.out_valid, int'(if_fix.out_idx), busy_f, ovf_f);
      mon(1, int'(pend_r), if_rr.out_valid, int'(if_rr.out_idx), busy_r, ovf_r);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    log_fix.delete();
    log_rr.delete();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) tick();
    check("reset pending", int'(pend_f), 0);
    check("reset out_valid", int'(if_fix.out_valid), 0);
    check("reset out_idx", int'(if_fix.out_idx), 0);
    check("reset ovf", int'(ovf_f), 0);
    check("reset busy", int'(busy_r), 0);
    rst_n = 1'b1;
    tick();

    // Single pulses: pending after 1 edge, grant visible after 2, valid for one cycle.
    for (int i = 0; i < N; i++) begin
      req = 8'(1 << i);
      tick();
      req = '0;
      check($sformatf("single%0d pending", i), int'(pend_f), 1 << i);
      check($sformatf("single%0d early valid", i), int'(if_fix.out_valid), 0);
      tick();
      check($sformatf("single%0d valid", i), int'(if_fix.out_valid), 1);
      check($sformatf("single%0d idx", i), int'(if_fix.out_idx), i);
      tick();
      check($sformatf("single%0d valid drop", i), int'(if_fix.out_valid), 0);
      repeat (7) tick();
    end

    clear_logs();
    req = 8'hA4;
    tick();
    req = '0;
    repeat (6) tick();
    check_s("A4 fixed order", log_str(log_fix), "7 5 2");
    check_s("A4 rr order", log_str(log_rr), "2 5 7");
    check("A4 pending drained", int'(pend_f), 0);
    check("A4 valid low", int'(if_fix.out_valid), 0);

    clear_logs();
    req = 8'hFF;
    tick();
    req = '0;
    repeat (12) tick();
    check_s("FF rr order", log_str(log_rr), "0 1 2 3 4 5 6 7");
    check_s("FF fixed order", log_str(log_fix), "7 6 5 4 3 2 1 0");

    clear_logs();
    req = 8'h81;
    tick();
    req = '0;
    repeat (5) tick();
    check_s("81 rr order", log_str(log_rr), "0 7");
    check_s("81 fixed order", log_str(log_fix), "7 0");

    // Backpressure: grant of 3 must hold steady until the consumer is ready.
    clear_logs();
    out_ready = 1'b0;
    req = 8'h08;
    tick();
    req = '0;
    tick();
    for (int j = 0; j < 5; j++) begin
      check($sformatf("stall%0d valid", j), int'(if_fix.out_valid), 1);
      check($sformatf("stall%0d idx", j), int'(if_fix.out_idx), 3);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall released", int'(if_fix.out_valid), 0);
    check_s("stall fixed log", log_str(log_fix), "3");
    check_s("stall rr log", log_str(log_rr), "3");

    // Overflow: slot held by grant 1, then two pulses on line 4 merge into one.
    clear_logs();
    out_ready = 1'b0;
    req = 8'h02;
    tick();
    req = '0;
    tick();
    req = 8'h10;
    tick();
    req = '0;
    tick();
    req = 8'h10;
    tick();
    req = '0;
    check("ovf fixed set", int'(ovf_f), 1);
    check("ovf rr set", int'(ovf_r), 1);
    check("ovf pending merged", int'(pend_f), 8'h10);
    out_ready = 1'b1;
    repeat (4) tick();
    check_s("ovf fixed log", log_str(log_fix), "1 4");
    check_s("ovf rr log", log_str(log_rr), "1 4");
    check("ovf still sticky", int'(ovf_f), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf fixed cleared", int'(ovf_f), 0);
    check("ovf rr cleared", int'(ovf_r), 0);

    // Async reset with work in flight.
    clear_logs();
    out_ready = 1'b0;
    req = 8'h01;
    tick();
    req = '0;
    tick();
    req = 8'h3C;
    tick();
    req = '0;
    check("prereset pending", int'(pend_f), 8'h3C);
    check("prereset valid", int'(if_fix.out_valid), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async pending", int'(pend_f), 0);
    check("async valid", int'(if_fix.out_valid), 0);
    check("async idx", int'(if_fix.out_idx), 0);
    check("async busy", int'(busy_f), 0);
    check("async rr pending", int'(pend_r), 0);
    check("async rr valid", int'(if_rr.out_valid), 0);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    check("post reset idle", int'(if_fix.out_valid), 0);
    check_s("post reset no grant", log_str(log_fix), "");

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      req       = 8'($urandom() & $urandom() & $urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    req = '0; ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (20) tick();
    check("drain fixed queue", exp_fix.size(), 0);
    check("drain rr queue", exp_rr.size(), 0);
    check("drain fixed valid", int'(if_fix.out_valid), 0);
    check("drain rr busy", int'(busy_r), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
